// File: rtl/growl_phase_seq.sv
// Multi-cycle phase sequencer for the growl AVR core: phase counting, mem-ready waits, skips.
// Define GROWL_IRQ_SEQ_EN to build the interrupt-entry sequence (IRQ state, irq_req/irq_ack).

module growl_phase_seq #(
    parameter int unsigned PHASE_W  = 3,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        inst_i,
    input  logic               inst_valid_i,
    input  logic               mem_ready_i,
    input  logic               skip_req_i,
    input  logic               flush_i,
    input  logic               irq_req_i,
    output logic [PHASE_W-1:0] phase_o,
    output logic               last_phase_o,
    output logic               pc_stall_o,
    output logic               discard_o,
    output logic               busy_o,
    output logic               bus_err_o,
    output logic               irq_ack_o
);

    localparam int unsigned WAIT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {IDLE, EXEC, SKIP, IRQ} state_e;

    // Phase count minus one for the instruction word at fetch.
    function automatic logic [1:0] decode_last(input logic [15:0] w);
        logic [1:0] r;
        r = 2'd0;
        if (w == 16'h9508 || w == 16'h9518)                          r = 2'd3;
        else if (w == 16'h9509 || w == 16'h95C8)                     r = 2'd2;
        else if (w[15:9] == 7'b1001010 && w[3:1] == 3'b111)          r = 2'd3;
        else if (w[15:9] == 7'b1001010 && w[3:1] == 3'b110)          r = 2'd2;
        else if (w[15:12] == 4'b1101)                                r = 2'd2;
        else if (w[15:9] == 7'b1001000 && w[3:1] == 3'b010)          r = 2'd2;
        else if (w[15:9] == 7'b1001011)                              r = 2'd1;
        else if (w[15:10] == 6'b100100 &&
                 (w[3:0] == 4'b0000 || w[3:2] == 2'b11 ||
                  (w[3:2] == 2'b00 && w[0]) || w[3:0] == 4'b0010))   r = 2'd1;
        else if (w[15:14] == 2'b10 && !w[12])                        r = 2'd1;
        return r;
    endfunction

    function automatic logic decode_two(input logic [15:0] w);
        return (w[15:9] == 7'b1001010 && w[3:2] == 2'b11) ||
               (w[15:10] == 6'b100100 && w[3:0] == 4'b0000);
    endfunction

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [1:0]         n_last_q, n_last_d;
    logic               w2_q, w2_d;
    logic [1:0]         skip_cnt_q, skip_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;

    logic exec_last_c, irq_last_c, timeout_c, skip_done_c, irq_go_c, launch_c;

    assign exec_last_c = (state_q == EXEC) && (phase_q == PHASE_W'(n_last_q));
    assign irq_last_c  = (state_q == IRQ) && (phase_q == PHASE_W'(2'd3));
    assign timeout_c   = (state_q == EXEC) && (wait_cnt_q == WAIT_W'(WAIT_MAX));
    assign skip_done_c = (state_q == SKIP) && (skip_cnt_q == (w2_q ? 2'd2 : 2'd1));

`ifdef GROWL_IRQ_SEQ_EN
    logic flush_pend_q, flush_pend_d;
    assign irq_go_c = irq_req_i;
`else
    logic unused_irq_req;
    assign unused_irq_req = irq_req_i;
    assign irq_go_c       = 1'b0;
`endif

    // Next-state logic; flush overrides everything except an interrupt entry in flight.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        n_last_d   = n_last_q;
        w2_d       = w2_q;
        skip_cnt_d = skip_cnt_q;
        wait_cnt_d = wait_cnt_q;
        launch_c   = 1'b0;
`ifdef GROWL_IRQ_SEQ_EN
        flush_pend_d = flush_pend_q;
`endif
        case (state_q)
            IDLE: launch_c = inst_valid_i;
            EXEC: begin
                if (timeout_c) begin
                    state_d    = IDLE;
                    phase_d    = '0;
                    wait_cnt_d = '0;
                end else if (!mem_ready_i) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end else begin
                    wait_cnt_d = '0;
                    if (!exec_last_c) begin
                        phase_d = phase_q + PHASE_W'(1);
                    end else if (skip_req_i) begin
                        state_d    = SKIP;
                        phase_d    = '0;
                        skip_cnt_d = '0;
                    end else if (irq_go_c) begin
                        state_d = IRQ;
                        phase_d = '0;
                    end else if (inst_valid_i) begin
                        launch_c = 1'b1;
                    end else begin
                        state_d = IDLE;
                        phase_d = '0;
                    end
                end
            end
            SKIP: begin
                if (skip_done_c) begin
                    if (irq_go_c) begin
                        state_d = IRQ;
                        phase_d = '0;
                    end else if (inst_valid_i) begin
                        launch_c = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (inst_valid_i) begin
                    skip_cnt_d = skip_cnt_q + 2'd1;
                    if (skip_cnt_q == 2'd0) begin
                        w2_d = decode_two(inst_i);
                    end
                end
            end
`ifdef GROWL_IRQ_SEQ_EN
            // A flush seen during the vector sequence is held until phase 3 completes.
            IRQ: begin
                if (irq_last_c) begin
                    phase_d      = '0;
                    flush_pend_d = 1'b0;
                    if (!flush_i && !flush_pend_q && inst_valid_i) begin
                        launch_c = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    phase_d      = phase_q + PHASE_W'(1);
                    flush_pend_d = flush_pend_q | flush_i;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase

        if (launch_c) begin
            state_d    = EXEC;
            phase_d    = '0;
            wait_cnt_d = '0;
            n_last_d   = decode_last(inst_i);
        end
        if (flush_i && state_q != IRQ) begin
            state_d    = IDLE;
            phase_d    = '0;
            wait_cnt_d = '0;
            skip_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            n_last_q   <= '0;
            w2_q       <= 1'b0;
            skip_cnt_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            n_last_q   <= n_last_d;
            w2_q       <= w2_d;
            skip_cnt_q <= skip_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef GROWL_IRQ_SEQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_pend_q <= 1'b0;
        end else begin
            flush_pend_q <= flush_pend_d;
        end
    end
    assign irq_ack_o = irq_last_c;
`else
    assign irq_ack_o = 1'b0;
`endif

    assign phase_o      = phase_q;
    assign last_phase_o = exec_last_c || irq_last_c;
    assign pc_stall_o   = ((state_q == EXEC) && (!exec_last_c || !mem_ready_i)) || (state_q == IRQ);
    assign discard_o    = (state_q == SKIP) && !skip_done_c;
    assign busy_o       = (state_q != IDLE);
    assign bus_err_o    = timeout_c;

endmodule

// File: tb/tb_growl_phase_seq.sv
// Directed self-checking bench for growl_phase_seq; IRQ scenarios follow GROWL_IRQ_SEQ_EN.

module tb_growl_phase_seq;

    localparam int unsigned PHASE_W  = 3;
    localparam int unsigned WAIT_MAX = 15;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [15:0]        inst;
    logic               inst_valid;
    logic               mem_ready;
    logic               skip_req;
    logic               flush;
    logic               irq_req;
    logic [PHASE_W-1:0] phase;
    logic               last_phase;
    logic               pc_stall;
    logic               discard;
    logic               busy;
    logic               bus_err;
    logic               irq_ack;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    growl_phase_seq #(.PHASE_W(PHASE_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst_i       (inst),
        .inst_valid_i (inst_valid),
        .mem_ready_i  (mem_ready),
        .skip_req_i   (skip_req),
        .flush_i      (flush),
        .irq_req_i    (irq_req),
        .phase_o      (phase),
        .last_phase_o (last_phase),
        .pc_stall_o   (pc_stall),
        .discard_o    (discard),
        .busy_o       (busy),
        .bus_err_o    (bus_err),
        .irq_ack_o    (irq_ack)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst = 16'h0000; inst_valid = 1'b0; mem_ready = 1'b1;
        skip_req = 1'b0; flush = 1'b0; irq_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        inst = 16'h940E; inst_valid = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({phase, last_phase, pc_stall, discard, busy, bus_err, irq_ack} !== 9'h000) begin
            bad++;
            $display("FAIL reset_outputs: got %h exp 000",
                     {phase, last_phase, pc_stall, discard, busy, bus_err, irq_ack});
        end
        inst_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_idle_busy: got %b exp 0", busy);
        end
    endtask

    task automatic test_nop();
        inst = 16'h0000; inst_valid = 1'b1; mem_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            inst_valid = (c < 5);
            #1;
            total++;
            if ({phase, last_phase, pc_stall, busy} !== {3'd0, 1'b1, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL nop_stream c%0d: got ph=%0d last=%b stall=%b busy=%b exp 0 1 0 1",
                         c, phase, last_phase, pc_stall, busy);
            end
        end
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL nop_end_busy: got %b exp 0", busy);
        end
    endtask

    // Back-to-back instructions, covering every phase-count class of the decode.
    task automatic test_back_to_back();
        logic [15:0] ops [0:20];
        int          nph [0:20];
        logic        lst;
        ops = '{16'h9601, 16'h900C, 16'h0000, 16'h940E, 16'h940C, 16'hD000, 16'h9508,
                16'h9518, 16'h9509, 16'h95C8, 16'h9004, 16'h9000, 16'h920F, 16'h8000,
                16'h9001, 16'h9002, 16'h9006, 16'h1001, 16'h9401, 16'h9A00, 16'hA000};
        nph = '{2, 2, 1, 4, 3, 3, 4, 4, 3, 3, 3, 2, 2, 2, 2, 2, 1, 1, 1, 1, 2};
        idle_inputs();
        inst = ops[0]; inst_valid = 1'b1;
        for (int i = 0; i < 21; i++) begin
            for (int k = 0; k < nph[i]; k++) begin
                step();
                lst        = (k == nph[i] - 1);
                inst_valid = lst && (i < 20);
                inst       = (lst && i < 20) ? ops[i+1] : 16'h0000;
                #1;
                total++;
                if ({phase, last_phase, pc_stall, busy} !== {3'(k), lst, !lst, 1'b1}) begin
                    bad++;
                    $display("FAIL b2b op%0d(%h) k%0d: got ph=%0d last=%b stall=%b busy=%b exp %0d %b %b 1",
                             i, ops[i], k, phase, last_phase, pc_stall, busy, k, lst, !lst);
                end
            end
        end
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL b2b_end_busy: got %b exp 0", busy);
        end
    endtask

    task automatic test_mem_wait();
        int lows [0:1];
        lows = '{3, 14};
        for (int t = 0; t < 2; t++) begin
            idle_inputs();
            inst = 16'h900C; inst_valid = 1'b1;
            for (int j = 0; j < lows[t]; j++) begin
                step();
                inst_valid = 1'b0; mem_ready = 1'b0;
                #1;
                total++;
                if ({phase, last_phase, pc_stall, bus_err} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
                    bad++;
                    $display("FAIL wait%0d_hold j%0d: got ph=%0d last=%b stall=%b err=%b exp 0 0 1 0",
                             lows[t], j, phase, last_phase, pc_stall, bus_err);
                end
            end
            step(); mem_ready = 1'b1; #1;
            total++;
            if ({phase, bus_err} !== {3'd0, 1'b0}) begin
                bad++; $display("FAIL wait%0d_ready: got ph=%0d err=%b exp 0 0", lows[t], phase, bus_err);
            end
            step(); mem_ready = 1'b0; #1;
            total++;
            if ({phase, last_phase, pc_stall, bus_err} !== {3'd1, 1'b1, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL wait%0d_last_stall: got ph=%0d last=%b stall=%b err=%b exp 1 1 1 0",
                         lows[t], phase, last_phase, pc_stall, bus_err);
            end
            step(); mem_ready = 1'b1; #1;
            total++;
            if ({phase, last_phase, pc_stall} !== {3'd1, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL wait%0d_last_go: got ph=%0d last=%b stall=%b exp 1 1 0",
                         lows[t], phase, last_phase, pc_stall);
            end
            step();
            total++;
            if ({busy, bus_err} !== 2'b00) begin
                bad++; $display("FAIL wait%0d_end: got busy=%b err=%b exp 0 0", lows[t], busy, bus_err);
            end
        end
    endtask

    task automatic test_timeout();
        idle_inputs();
        inst = 16'h900C; inst_valid = 1'b1;
        for (int j = 0; j <= 15; j++) begin
            step();
            inst_valid = 1'b0; mem_ready = 1'b0;
            #1;
            total++;
            if ({bus_err, busy, phase} !== {(j == 15), 1'b1, 3'd0}) begin
                bad++;
                $display("FAIL timeout j%0d: got err=%b busy=%b ph=%0d exp %b 1 0",
                         j, bus_err, busy, phase, (j == 15));
            end
        end
        step();
        mem_ready = 1'b1;
        #1;
        total++;
        if ({busy, bus_err} !== 2'b00) begin
            bad++; $display("FAIL timeout_idle: got busy=%b err=%b exp 0 0", busy, bus_err);
        end
    endtask

    // CPSE skipping a 2-word JMP, then a 1-word ADIW; a CPSE-shaped operand word must not chain.
    task automatic test_skip();
        logic [15:0] words [0:1][0:1];
        int          nd [0:1];
        words = '{'{16'h940C, 16'h1001}, '{16'h9601, 16'h0000}};
        nd    = '{2, 1};
        for (int t = 0; t < 2; t++) begin
            idle_inputs();
            inst = 16'h1001; inst_valid = 1'b1;
            step();
            inst = 16'h0000; inst_valid = 1'b0; skip_req = 1'b1;
            #1;
            total++;
            if ({phase, last_phase, discard, busy} !== {3'd0, 1'b1, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL skip%0d_cpse: got ph=%0d last=%b disc=%b busy=%b exp 0 1 0 1",
                         t, phase, last_phase, discard, busy);
            end
            for (int d = 0; d < nd[t]; d++) begin
                step();
                inst = words[t][d]; inst_valid = 1'b1; skip_req = 1'b1;
                #1;
                total++;
                if ({discard, busy, pc_stall} !== 3'b110) begin
                    bad++;
                    $display("FAIL skip%0d_discard d%0d: got disc=%b busy=%b stall=%b exp 1 1 0",
                             t, d, discard, busy, pc_stall);
                end
            end
            step();
            inst = 16'h9601; inst_valid = 1'b1; skip_req = 1'b0;
            #1;
            total++;
            if ({discard, busy} !== 2'b01) begin
                bad++; $display("FAIL skip%0d_exit: got disc=%b busy=%b exp 0 1", t, discard, busy);
            end
            step(); inst_valid = 1'b0; #1;
            total++;
            if ({phase, last_phase, discard, busy} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL skip%0d_next_ph0: got ph=%0d last=%b disc=%b busy=%b exp 0 0 0 1",
                         t, phase, last_phase, discard, busy);
            end
            step();
            total++;
            if ({phase, last_phase} !== {3'd1, 1'b1}) begin
                bad++; $display("FAIL skip%0d_next_ph1: got ph=%0d last=%b exp 1 1", t, phase, last_phase);
            end
            step();
            total++;
            if (busy !== 1'b0) begin
                bad++; $display("FAIL skip%0d_end: got busy=%b exp 0", t, busy);
            end
        end
    endtask

    task automatic test_flush();
        idle_inputs();
        inst = 16'h940E; inst_valid = 1'b1;
        step(); inst_valid = 1'b0; #1;
        step(); flush = 1'b1; #1;
        total++;
        if ({phase, busy} !== {3'd1, 1'b1}) begin
            bad++; $display("FAIL flush_call_pre: got ph=%0d busy=%b exp 1 1", phase, busy);
        end
        step(); flush = 1'b0; #1;
        total++;
        if ({phase, last_phase, busy} !== {3'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL flush_call: got ph=%0d last=%b busy=%b exp 0 0 0", phase, last_phase, busy);
        end
        inst = 16'h1001; inst_valid = 1'b1;
        step(); inst_valid = 1'b0; skip_req = 1'b1; flush = 1'b1; #1;
        step(); skip_req = 1'b0; flush = 1'b0; #1;
        total++;
        if ({discard, busy} !== 2'b00) begin
            bad++; $display("FAIL flush_over_skip: got disc=%b busy=%b exp 0 0", discard, busy);
        end
        inst = 16'h9601; inst_valid = 1'b1; flush = 1'b1;
        step(); inst_valid = 1'b0; flush = 1'b0; #1;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL flush_idle_launch: got busy=%b exp 0", busy);
        end
    endtask

`ifdef GROWL_IRQ_SEQ_EN
    task automatic test_irq();
        for (int r = 0; r < 2; r++) begin
            idle_inputs();
            inst = 16'h9601; inst_valid = 1'b1;
            step(); inst_valid = 1'b0; #1;
            step(); irq_req = 1'b1; #1;
            for (int p = 0; p < 4; p++) begin
                step();
                irq_req = 1'b0; flush = (r == 0 && p == 1);
                inst = 16'h0000; inst_valid = (p == 3);
                #1;
                total++;
                if ({phase, pc_stall, irq_ack, last_phase, busy} !== {3'(p), 1'b1, (p == 3), (p == 3), 1'b1}) begin
                    bad++;
                    $display("FAIL irq%0d_p%0d: got ph=%0d stall=%b ack=%b last=%b busy=%b", r, p,
                             phase, pc_stall, irq_ack, last_phase, busy);
                end
            end
            step(); flush = 1'b0; inst_valid = 1'b0; #1;
            total++;
            if ({busy, phase, last_phase} !== ((r == 0) ? {1'b0, 3'd0, 1'b0} : {1'b1, 3'd0, 1'b1})) begin
                bad++;
                $display("FAIL irq%0d_after: got busy=%b ph=%0d last=%b", r, busy, phase, last_phase);
            end
            if (r == 1) step();
        end
        idle_inputs();
        inst = 16'h1001; inst_valid = 1'b1;
        step(); inst_valid = 1'b0; skip_req = 1'b1; irq_req = 1'b1; #1;
        step(); inst = 16'h9601; inst_valid = 1'b1; skip_req = 1'b0; #1;
        total++;
        if ({discard, irq_ack, pc_stall} !== 3'b100) begin
            bad++; $display("FAIL irq_skip_wins: got disc=%b ack=%b stall=%b exp 1 0 0", discard, irq_ack, pc_stall);
        end
        step(); inst_valid = 1'b0; #1;
        for (int p = 0; p < 4; p++) begin
            step(); irq_req = 1'b0; #1;
            total++;
            if ({phase, pc_stall, irq_ack, discard} !== {3'(p), 1'b1, (p == 3), 1'b0}) begin
                bad++;
                $display("FAIL irq_after_skip p%0d: got ph=%0d stall=%b ack=%b disc=%b", p,
                         phase, pc_stall, irq_ack, discard);
            end
        end
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL irq_skip_end: got busy=%b exp 0", busy);
        end
    endtask
`else
    task automatic test_irq();
        idle_inputs();
        inst = 16'h9601; inst_valid = 1'b1;
        step(); inst_valid = 1'b0; #1;
        step(); irq_req = 1'b1; #1;
        step(); #1;
        total++;
        if ({busy, irq_ack, pc_stall} !== 3'b000) begin
            bad++; $display("FAIL irq_ignored: got busy=%b ack=%b stall=%b exp 0 0 0", busy, irq_ack, pc_stall);
        end
        irq_req = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_nop();
        test_back_to_back();
        test_mem_wait();
        test_timeout();
        test_skip();
        test_flush();
        test_irq();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
